// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receiver and transmitter.
//   UART_DATA_W : data bits per frame
//   rx_state_t  : receiver FSM state encoding
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if
// Valid/ready byte stream leaving the UART receiver.
//   rx_data  : received byte, meaningful while rx_valid=1
//   rx_valid : byte available, held until accepted
//   rx_ready : consumer accepts the byte when rx_valid & rx_ready
// Modports: master (receiver side), slave (consumer side).
// ----------------------------------------------------------------------------
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] rx_data;
    logic                   rx_valid;
    logic                   rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for the asynchronous serial line. Resets to 1 so the
// idle-high line does not look like a start bit when reset is released.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronised output (2-cycle delay)
// ----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), LSB first.
// Samples each bit at mid-period and hands bytes downstream through a
// one-entry valid/ready holding register. Framing, parity and overrun
// errors are reported as 1-cycle pulses.
//
// Parameters:
//   CLK_HZ : system clock frequency in Hz
//   BAUD   : line rate in bit/s (CLK_HZ/BAUD must be >= 8)
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   rx         : serial line, idle high, asynchronous to clk
//   bus        : uart_rx_if.master (rx_data, rx_valid, rx_ready)
//   busy       : FSM not in IDLE
//   frame_err  : pulse, stop bit sampled 0
//   parity_err : pulse, even-parity mismatch (tied 0 without the macro)
//   overrun    : pulse, byte dropped because the holding register was full
// Configuration macro: UART_RX_PARITY_EN
// ----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.master bus,
    output logic      busy,
    output logic      frame_err,
    output logic      parity_err,
    output logic      overrun
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int IW           = $clog2(UART_DATA_W);

    logic                   rx_s;
    rx_state_t              state, state_next;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          bit_idx;
    logic [UART_DATA_W-1:0] shreg;
    logic                   tick, half;
    logic                   shift_en, deliver, frame_hit, byte_ok;
`ifdef UART_RX_PARITY_EN
    logic                   par_en, par_bad;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign tick = (cnt == CW'(CLKS_PER_BIT - 1));
    assign half = (cnt == CW'(CLKS_PER_BIT / 2 - 1));
    assign busy = (state != RX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RX_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        deliver    = 1'b0;
        frame_hit  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en     = 1'b0;
`endif
        case (state)
            RX_IDLE: begin
                if (!rx_s) state_next = RX_START;
            end
            RX_START: begin
                // Mid start bit: a line already back high was a glitch.
                if (half) state_next = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    if (bit_idx == IW'(UART_DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_next = RX_PARITY;
`else
                        state_next = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (tick) begin
                    par_en     = 1'b1;
                    state_next = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        deliver    = 1'b1;
                        state_next = RX_IDLE;
                    end else begin
                        frame_hit  = 1'b1;
                        state_next = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (rx_s) state_next = RX_IDLE;
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // Counter restarts on every state change; inside DATA it wraps each bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            cnt <= '0;
        else if (state_next != state || tick) cnt <= '0;
        else                                   cnt <= cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state != RX_DATA)  bit_idx <= '0;
            else if (shift_en)     bit_idx <= bit_idx + IW'(1);
            if (shift_en)          shreg   <= {rx_s, shreg[UART_DATA_W-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits XOR parity bit must be 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      par_bad <= 1'b0;
        else if (par_en) par_bad <= (^shreg) ^ rx_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_err <= 1'b0;
        else        parity_err <= deliver & par_bad;
    end

    assign byte_ok = deliver & ~par_bad;
`else
    assign parity_err = 1'b0;
    assign byte_ok    = deliver;
`endif

    // Holding register: a delivery coinciding with an accept replaces the
    // old byte without raising overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_err <= frame_hit;
            overrun   <= byte_ok & bus.rx_valid & ~bus.rx_ready;
            if (byte_ok && (!bus.rx_valid || bus.rx_ready)) begin
                bus.rx_data  <= shreg;
                bus.rx_valid <= 1'b1;
            end else if (bus.rx_valid && bus.rx_ready) begin
                bus.rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx at 16 clocks per bit. Honors UART_RX_PARITY_EN.
// ----------------------------------------------------------------------------
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    logic busy, frame_err, parity_err, overrun;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_HZ (1_600_000),
        .BAUD   (100_000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .bus        (bus),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_start = 0;

    // Monitor state (written only by the monitor)
    int   rise_cyc = 0;
    int   n_valid = 0, n_frame = 0, n_par = 0, n_ovr = 0, n_busy = 0;
    logic prev_valid = 1'b0;
    logic [7:0] acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_valid) n_valid++;
        if (bus.rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = bus.rx_valid;
        if (frame_err)  n_frame++;
        if (parity_err) n_par++;
        if (overrun)    n_ovr++;
        if (busy)       n_busy++;
        if (bus.rx_valid && bus.rx_ready) acc_q.push_back(bus.rx_data);
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic par_flip, input int extra_low);
        @(posedge clk); #1;
        rx = 1'b0;
        last_start = cyc;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = d[i];
            repeat (16) @(posedge clk);
        end
`ifdef UART_RX_PARITY_EN
        #1 rx = (^d) ^ par_flip;
        repeat (16) @(posedge clk);
`endif
        #1 rx = stop;
        repeat (16) @(posedge clk);
        if (!stop) begin
            repeat (extra_low) @(posedge clk);
            #1 rx = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rx = 1'b1;
        bus.rx_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset rx_data: got %h expected 00", bus.rx_data); end
        n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset rx_valid: got %b expected 0", bus.rx_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin n_fail++; $display("FAIL reset errors: got %b expected 000", {frame_err, parity_err, overrun}); end
        @(posedge clk); #1 rst_n = 1'b1;
        idle(5);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset idle busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic_rx;
        int b_acc, b_val, b_fr, b_par, b_ovr;
        bus.rx_ready = 1'b1;
        b_acc = acc_q.size(); b_val = n_valid; b_fr = n_frame; b_par = n_par; b_ovr = n_ovr;
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        idle(20);
        n_checks++; if (acc_q.size() - b_acc !== 1) begin n_fail++; $display("FAIL basic count: got %0d expected 1", acc_q.size() - b_acc); end
        else begin
            n_checks++; if (acc_q[b_acc] !== 8'hA5) begin n_fail++; $display("FAIL basic data: got %h expected a5", acc_q[b_acc]); end
        end
        n_checks++; if (n_valid - b_val !== 1) begin n_fail++; $display("FAIL basic valid cycles: got %0d expected 1", n_valid - b_val); end
        n_checks++; if (rise_cyc - last_start !== LAT) begin n_fail++; $display("FAIL basic latency: got %0d expected %0d", rise_cyc - last_start, LAT); end
        n_checks++; if (n_frame - b_fr !== 0) begin n_fail++; $display("FAIL basic frame_err: got %0d expected 0", n_frame - b_fr); end
        n_checks++; if (n_par - b_par !== 0) begin n_fail++; $display("FAIL basic parity_err: got %0d expected 0", n_par - b_par); end
        n_checks++; if (n_ovr - b_ovr !== 0) begin n_fail++; $display("FAIL basic overrun: got %0d expected 0", n_ovr - b_ovr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic busy after: got %b expected 0", busy); end
    endtask

    task automatic test_glitch;
        int b_val, b_fr, b_busy;
        b_val = n_valid; b_fr = n_frame; b_busy = n_busy;
        @(posedge clk); #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        idle(30);
        n_checks++; if (n_busy - b_busy < 1) begin n_fail++; $display("FAIL glitch busy seen: got %0d expected >0", n_busy - b_busy); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch idle: got busy %b expected 0", busy); end
        n_checks++; if (n_valid - b_val !== 0) begin n_fail++; $display("FAIL glitch valid: got %0d expected 0", n_valid - b_val); end
        n_checks++; if (n_frame - b_fr !== 0) begin n_fail++; $display("FAIL glitch frame_err: got %0d expected 0", n_frame - b_fr); end
    endtask

    task automatic test_frame_error;
        int b_acc, b_val, b_fr;
        bus.rx_ready = 1'b1;
        b_acc = acc_q.size(); b_val = n_valid; b_fr = n_frame;
        send_frame(8'h3C, 1'b0, 1'b0, 40);
        idle(20);
        n_checks++; if (n_frame - b_fr !== 1) begin n_fail++; $display("FAIL frame pulses: got %0d expected 1", n_frame - b_fr); end
        n_checks++; if (n_valid - b_val !== 0) begin n_fail++; $display("FAIL frame valid: got %0d expected 0", n_valid - b_val); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frame idle: got busy %b expected 0", busy); end
        send_frame(8'h55, 1'b1, 1'b0, 0);
        idle(20);
        n_checks++; if (acc_q.size() - b_acc !== 1) begin n_fail++; $display("FAIL frame next count: got %0d expected 1", acc_q.size() - b_acc); end
        else begin
            n_checks++; if (acc_q[b_acc] !== 8'h55) begin n_fail++; $display("FAIL frame next data: got %h expected 55", acc_q[b_acc]); end
        end
        n_checks++; if (n_frame - b_fr !== 1) begin n_fail++; $display("FAIL frame pulses after good: got %0d expected 1", n_frame - b_fr); end
    endtask

    task automatic test_overrun;
        int b_acc, b_ovr;
        bus.rx_ready = 1'b0;
        b_acc = acc_q.size(); b_ovr = n_ovr;
        send_frame(8'h11, 1'b1, 1'b0, 0);
        send_frame(8'h22, 1'b1, 1'b0, 0);
        idle(10);
        n_checks++; if (bus.rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr valid held: got %b expected 1", bus.rx_valid); end
        n_checks++; if (bus.rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr data held: got %h expected 11", bus.rx_data); end
        n_checks++; if (n_ovr - b_ovr !== 1) begin n_fail++; $display("FAIL ovr pulses: got %0d expected 1", n_ovr - b_ovr); end
        @(posedge clk); #1 bus.rx_ready = 1'b1;
        @(posedge clk); #1 bus.rx_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr accept drop: got %b expected 0", bus.rx_valid); end
        n_checks++; if (acc_q.size() - b_acc !== 1) begin n_fail++; $display("FAIL ovr accepted count: got %0d expected 1", acc_q.size() - b_acc); end
    endtask

    task automatic test_back_to_back;
        int b_acc, b_ovr;
        bus.rx_ready = 1'b0;
        b_acc = acc_q.size(); b_ovr = n_ovr;
        send_frame(8'h11, 1'b1, 1'b0, 0);
        fork
            send_frame(8'h22, 1'b1, 1'b0, 0);
            begin
                @(posedge clk); #1;
                repeat (LAT - 1) @(posedge clk);
                #1 bus.rx_ready = 1'b1;
                @(posedge clk); #1 bus.rx_ready = 1'b0;
            end
        join
        idle(5);
        n_checks++; if (bus.rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b valid: got %b expected 1", bus.rx_valid); end
        n_checks++; if (bus.rx_data !== 8'h22) begin n_fail++; $display("FAIL b2b data: got %h expected 22", bus.rx_data); end
        n_checks++; if (n_ovr - b_ovr !== 0) begin n_fail++; $display("FAIL b2b overrun: got %0d expected 0", n_ovr - b_ovr); end
        n_checks++; if (acc_q.size() - b_acc !== 1) begin n_fail++; $display("FAIL b2b accepted count: got %0d expected 1", acc_q.size() - b_acc); end
        else begin
            n_checks++; if (acc_q[b_acc] !== 8'h11) begin n_fail++; $display("FAIL b2b first byte: got %h expected 11", acc_q[b_acc]); end
        end
        @(posedge clk); #1 bus.rx_ready = 1'b1;
        @(posedge clk); #1 bus.rx_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b drain: got %b expected 0", bus.rx_valid); end
    endtask

    task automatic test_reset_mid_frame;
        int b_val, b_acc;
        bus.rx_ready = 1'b1;
        fork
            send_frame(8'hFF, 1'b1, 1'b0, 0);
            begin
                @(posedge clk); #1;
                repeat (88) @(posedge clk);
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst busy before: got %b expected 1", busy); end
                #1 rst_n = 1'b0;
                @(negedge clk);
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst busy: got %b expected 0", busy); end
                n_checks++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst rx_data: got %h expected 00", bus.rx_data); end
                n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst rx_valid: got %b expected 0", bus.rx_valid); end
                n_checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin n_fail++; $display("FAIL midrst errors: got %b expected 000", {frame_err, parity_err, overrun}); end
                @(posedge clk); #1 rst_n = 1'b1;
            end
        join
        b_val = n_valid;
        idle(20);
        n_checks++; if (n_valid - b_val !== 0) begin n_fail++; $display("FAIL midrst spurious valid: got %0d expected 0", n_valid - b_val); end
        b_acc = acc_q.size();
        send_frame(8'h81, 1'b1, 1'b0, 0);
        idle(20);
        n_checks++; if (acc_q.size() - b_acc !== 1) begin n_fail++; $display("FAIL midrst next count: got %0d expected 1", acc_q.size() - b_acc); end
        else begin
            n_checks++; if (acc_q[b_acc] !== 8'h81) begin n_fail++; $display("FAIL midrst next data: got %h expected 81", acc_q[b_acc]); end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int b_val, b_par, b_fr;
        bus.rx_ready = 1'b1;
        b_val = n_valid; b_par = n_par; b_fr = n_frame;
        send_frame(8'h07, 1'b1, 1'b1, 0);
        idle(20);
        n_checks++; if (n_par - b_par !== 1) begin n_fail++; $display("FAIL parity pulses: got %0d expected 1", n_par - b_par); end
        n_checks++; if (n_valid - b_val !== 0) begin n_fail++; $display("FAIL parity valid: got %0d expected 0", n_valid - b_val); end
        n_checks++; if (n_frame - b_fr !== 0) begin n_fail++; $display("FAIL parity frame_err: got %0d expected 0", n_frame - b_fr); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_rx();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        n_checks++; if (n_par !== 0 && 0) begin n_fail++; end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
